// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and the pointer-rotated priority pick for rr_arbiter4.
// Pure combinational helpers; no latency, no backpressure.
package rr_arb_pkg;

    localparam int NREQ  = 4;
    localparam int PTR_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // Scan downwards so the requester closest to ptr is the last (and final) match.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [PTR_W-1:0] ptr);
        pick_t            p;
        logic [PTR_W-1:0] idx;
        p = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + PTR_W'(i);
            if (req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_ptr_counter.sv
// Wrapping round-robin priority pointer: loads owner index + 1 on release, else holds.
// Updates on the edge following i_load; no backpressure.
module rr_ptr_counter
    import rr_arb_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [PTR_W-1:0] i_base,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_base + PTR_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/rr_arbiter4.sv
// 4-way round-robin arbiter with held grants; grant 1 edge after request, 1-cycle bubble on release.
// No backpressure; optional tenure limit under RR_TIMEOUT_EN (revokes after HOLD_MAX cycles).
module rr_arbiter4
    import rr_arb_pkg::*;
`ifdef RR_TIMEOUT_EN
#(
    parameter int unsigned HOLD_MAX = 8
)
`endif
(
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic [NREQ-1:0]  i_req,
    output logic [NREQ-1:0]  o_grant,
    output logic [PTR_W-1:0] o_grant_id,
    output logic             o_grant_valid,
    output logic [PTR_W-1:0] o_ptr,
    output logic             o_timeout
);

    state_t           r_state;
    logic [NREQ-1:0]  r_grant;
    logic [PTR_W-1:0] r_grant_id;

    pick_t            w_pick;
    logic [PTR_W-1:0] w_ptr;
    logic             w_owner_req;
    logic             w_release;
    logic             w_revoke;

    assign w_pick      = rr_pick(i_req, w_ptr);
    assign w_owner_req = i_req[r_grant_id];
    assign w_release   = (r_state == GRANT) && !w_owner_req;

`ifdef RR_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_timeout;

    // A voluntary release in the final allowed cycle takes precedence over revocation.
    assign w_revoke  = (r_state == GRANT) && w_owner_req && (r_hold == HOLD_W'(HOLD_MAX));
    assign o_timeout = r_timeout;
`else
    assign w_revoke  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
`ifdef RR_TIMEOUT_EN
            r_hold     <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
`ifdef RR_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_pick.found) begin
                        r_state    <= GRANT;
                        r_grant    <= NREQ'(1) << w_pick.idx;
                        r_grant_id <= w_pick.idx;
`ifdef RR_TIMEOUT_EN
                        r_hold     <= HOLD_W'(1);
`endif
                    end
                end
                GRANT: begin
                    if (w_release || w_revoke) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end
`ifdef RR_TIMEOUT_EN
                    if (w_revoke) begin
                        r_timeout <= 1'b1;
                    end
                    r_hold <= r_hold + HOLD_W'(1);
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    rr_ptr_counter u_ptr (
        .i_clock (i_clock),
        .i_clear (i_clear),
        .i_load  (w_release || w_revoke),
        .i_base  (r_grant_id),
        .o_ptr   (w_ptr)
    );

    assign o_grant       = r_grant;
    assign o_grant_id    = r_grant_id;
    assign o_grant_valid = |r_grant;
    assign o_ptr         = w_ptr;

endmodule
